// File: rtl/keypad_pkg.sv
// Shared types, key constants and the row/column to key-code map for the keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD} kp_state_t;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  // Physical layout: r0 "1 2 3 A", r1 "4 5 6 B", r2 "7 8 9 C", r3 "* 0 # D"
  function automatic logic [3:0] kp_map(input logic [1:0] row_idx, input logic [1:0] col_idx);
    logic [3:0] code;
    case ({row_idx, col_idx})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = KEY_STAR;
      4'hD: code = 4'h0;
      4'hE: code = KEY_HASH;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, with a configurable reset value.
module sync_2ff #(
  parameter int              WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two back-to-back flops; only q is safe to use in the clk domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: walks an active-low row strobe, debounces single-key
// presses and releases, and emits one key_valid pulse per physical press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 27000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_MAX   = CW'(DEBOUNCE_SCANS);

  logic [3:0]    col_s;
  logic [DW-1:0] div;
  logic          tick;
  kp_state_t     state, state_n;
  logic [1:0]    row_idx, row_idx_n;
  logic [1:0]    lat_col, lat_col_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]    key_code_n;
  logic          key_valid_n, key_held_n;
  logic          cand;
  logic [1:0]    cand_col;
  logic          all_high;

  sync_2ff #(.WIDTH(4), .RST_VAL(4'b1111)) u_col_sync (
    .clk (clk),
    .rst (rst),
    .d   (col),
    .q   (col_s)
  );

  assign tick     = (div == DIV_LAST);
  assign row      = ~(4'b0001 << row_idx);
  assign all_high = &col_s;
  assign cnt_inc  = (cnt >= DB_MAX) ? cnt : cnt + CW'(1);

  // Row dwell divider; tick marks the end of each dwell.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) div <= '0;
    else if (tick) div <= '0;
    else div <= div + DW'(1);
  end

  // A press is only a candidate when exactly one column is pulled low.
  always_comb begin
    cand     = 1'b0;
    cand_col = 2'd0;
    case (col_s)
      4'b1110: begin cand = 1'b1; cand_col = 2'd0; end
      4'b1101: begin cand = 1'b1; cand_col = 2'd1; end
      4'b1011: begin cand = 1'b1; cand_col = 2'd2; end
      4'b0111: begin cand = 1'b1; cand_col = 2'd3; end
      default: ;
    endcase
  end

  // Scan/debounce/held state and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_SCAN;
      row_idx   <= 2'd0;
      lat_col   <= 2'd0;
      cnt       <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_n;
      row_idx   <= row_idx_n;
      lat_col   <= lat_col_n;
      cnt       <= cnt_n;
      key_code  <= key_code_n;
      key_valid <= key_valid_n;
      key_held  <= key_held_n;
    end
  end

  // Next-state logic; everything moves only on tick. Row is frozen while debouncing/held.
  always_comb begin
    state_n     = state;
    row_idx_n   = row_idx;
    lat_col_n   = lat_col;
    cnt_n       = cnt;
    key_code_n  = key_code;
    key_held_n  = key_held;
    key_valid_n = 1'b0;
    if (tick) begin
      case (state)
        S_SCAN: begin
          if (cand) begin
            lat_col_n = cand_col;
            if (DEBOUNCE_SCANS <= 1) begin
              key_code_n  = kp_map(row_idx, cand_col);
              key_valid_n = 1'b1;
              key_held_n  = 1'b1;
              cnt_n       = '0;
              state_n     = S_HELD;
            end else begin
              cnt_n   = CW'(1);
              state_n = S_DEBOUNCE;
            end
          end else begin
            row_idx_n = row_idx + 2'd1;
          end
        end
        S_DEBOUNCE: begin
          if (cand && cand_col == lat_col) begin
            if (cnt_inc >= DB_MAX) begin
              key_code_n  = kp_map(row_idx, lat_col);
              key_valid_n = 1'b1;
              key_held_n  = 1'b1;
              cnt_n       = '0;
              state_n     = S_HELD;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            cnt_n     = '0;
            row_idx_n = row_idx + 2'd1;
            state_n   = S_SCAN;
          end
        end
        S_HELD: begin
          if (all_high) begin
            if (cnt_inc >= DB_MAX) begin
              key_held_n = 1'b0;
              cnt_n      = '0;
              row_idx_n  = row_idx + 2'd1;
              state_n    = S_SCAN;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            cnt_n = '0;
          end
        end
        default: begin
          cnt_n   = '0;
          state_n = S_SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a resistive-short keypad model.
module tb_keypad_scanner;

  logic       clk;
  logic       rst;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys;      // bit r*4+c set = key at (r,c) pressed
  int          nvec;
  int          nerr;
  int          pulses;
  logic [3:0]  last_code;
  logic [3:0]  seen;
  int          row_bad;
  int          valid_in_rst;
  int          base;
  bit          found;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .col       (col),
    .row       (row),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad: a pressed key shorts its column to its row when that row is driven low.
  always_comb begin
    col = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
  end

  // Monitor: count pulses, capture codes, watch row legality.
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      pulses    = pulses + 1;
      last_code = key_code;
    end
    if (rst === 1'b0 && key_valid !== 1'b0) valid_in_rst = valid_in_rst + 1;
    case (row)
      4'b1110: seen[0] = 1'b1;
      4'b1101: seen[1] = 1'b1;
      4'b1011: seen[2] = 1'b1;
      4'b0111: seen[3] = 1'b1;
      default: row_bad = row_bad + 1;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec = nvec + 1;
    if (obs !== exp) begin
      nerr = nerr + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    nvec = 0; nerr = 0; pulses = 0; last_code = 4'h0;
    seen = 4'h0; row_bad = 0; valid_in_rst = 0;
    keys = 16'h0;
    rst  = 1'b0;
    clks(3);
    rst = 1'b1;

    // 1: async reset mid-dwell while row = 1011
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (row == 4'b1011) found = 1'b1;
    end
    chk("reach_row2", 32'(found), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("rst_row", 32'(row), 32'hE);
    chk("rst_code", 32'(key_code), 32'h0);
    chk("rst_valid", 32'(key_valid), 32'h0);
    chk("rst_held", 32'(key_held), 32'h0);
    clks(2);
    rst = 1'b1;

    // 2: press '5' steady, exactly one pulse, held, row frozen
    base = pulses;
    keys[1*4+1] = 1'b1;
    clks(40);
    chk("p5_pulses", 32'(pulses - base), 32'd1);
    chk("p5_code", 32'(last_code), 32'h5);
    chk("p5_held", 32'(key_held), 32'd1);
    chk("p5_row", 32'(row), 32'hD);
    clks(80);
    chk("p5_norepeat", 32'(pulses - base), 32'd1);
    chk("p5_row_frozen", 32'(row), 32'hD);

    // 4: '#' pressed while '5' held is ignored; release '5' then '#' accepted
    base = pulses;
    keys[3*4+2] = 1'b1;
    clks(40);
    chk("hash_ignored", 32'(pulses - base), 32'd0);
    chk("hash_code_kept", 32'(key_code), 32'h5);
    keys[1*4+1] = 1'b0;
    clks(4);
    chk("rel_held_early", 32'(key_held), 32'd1);
    clks(8);
    chk("rel_held_fall", 32'(key_held), 32'd0);
    chk("rel_nopulse", 32'(pulses - base), 32'd0);
    clks(40);
    chk("hash_pulse", 32'(pulses - base), 32'd1);
    chk("hash_code", 32'(last_code), 32'hF);
    chk("hash_held", 32'(key_held), 32'd1);
    keys[3*4+2] = 1'b0;
    clks(30);
    chk("hash_released", 32'(key_held), 32'd0);

    // 3: bounce 'A' each tick for 6 ticks, then hold steady
    base = pulses;
    for (int t = 0; t < 6; t++) begin
      keys[0*4+3] = (t % 2 == 0);
      clks(4);
    end
    chk("bounce_nopulse", 32'(pulses - base), 32'd0);
    keys[0*4+3] = 1'b1;
    clks(40);
    chk("a_pulse", 32'(pulses - base), 32'd1);
    chk("a_code", 32'(last_code), 32'hA);
    keys[0*4+3] = 1'b0;
    clks(30);

    // 5: two keys in the same row are ghosted; scanning continues
    base = pulses;
    keys[2*4+0] = 1'b1;
    keys[2*4+2] = 1'b1;
    clks(4);
    seen = 4'h0;
    clks(80);
    chk("ghost_nopulse", 32'(pulses - base), 32'd0);
    chk("ghost_rows_seen", 32'(seen), 32'hF);
    chk("ghost_held", 32'(key_held), 32'd0);
    keys = 16'h0;
    clks(20);

    // 6: '*' held, reset, re-acquired only after a fresh debounce
    base = pulses;
    keys[3*4+0] = 1'b1;
    clks(40);
    chk("star_pulse", 32'(pulses - base), 32'd1);
    chk("star_code", 32'(last_code), 32'hE);
    chk("star_held", 32'(key_held), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("star_rst_held", 32'(key_held), 32'd0);
    chk("star_rst_code", 32'(key_code), 32'h0);
    clks(3);
    chk("star_rst_held2", 32'(key_held), 32'd0);
    base = pulses;
    rst = 1'b1;
    clks(18);
    chk("star_no_early", 32'(pulses - base), 32'd0);
    clks(22);
    chk("star_repulse", 32'(pulses - base), 32'd1);
    chk("star_recode", 32'(last_code), 32'hE);
    chk("star_reheld", 32'(key_held), 32'd1);
    keys = 16'h0;
    clks(20);

    chk("row_onehot", 32'(row_bad), 32'd0);
    chk("valid_in_rst", 32'(valid_in_rst), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
